// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared constants, types and write-port arbitration for reg_file_mp
package reg_file_pkg;

  localparam int REG_N      = 8;
  localparam int REG_W      = 8;
  localparam int REG_A      = 3;
  localparam int REG_MAX_WR = 8;

  typedef logic [REG_A-1:0] reg_addr_t;
  typedef logic [REG_W-1:0] reg_data_t;

  // Highest-index set bit of a per-port hit mask; the last port to claim an address wins.
  function automatic int wr_select(input logic [REG_MAX_WR-1:0] hit);
    int sel;
    sel = 0;
    for (int k = 0; k < REG_MAX_WR; k++) begin
      if (hit[k]) sel = k;
    end
    return sel;
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - per-register pending-write bits; reserve beats a same-edge write clear
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREGS    = REG_N,
  parameter int A        = REG_A,
  parameter int ZERO_REG = 0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [NREGS-1:0] clr_i,
  input  logic             rsv_i,
  input  logic [A-1:0]     rsv_addr_i,
  output logic [NREGS-1:0] pending_o
);

  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;

  always_comb begin
    pend_d = pend_q & ~clr_i;
    if (rsv_i) pend_d[rsv_addr_i] = 1'b1;
    if (ZERO_REG != 0) pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) pend_q <= '0;
    else         pend_q <= pend_d;
  end

  assign pending_o = pend_q;

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with pending-write scoreboard
// Optional write-to-read forwarding when REG_FILE_BYPASS_EN is defined.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int NREGS    = REG_N,
  parameter int W        = REG_W,
  parameter int A        = REG_A,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [NWR-1:0]   WRITE,
  input  logic [NWR*A-1:0] INADDRESS,
  input  logic [NWR*W-1:0] IN,
  input  logic [NRD*A-1:0] OUTADDRESS,
  output logic [NRD*W-1:0] OUT,
  output logic [NRD-1:0]   OUTBUSY,
  input  logic             RSV,
  input  logic [A-1:0]     RSVADDRESS
);

  logic [W-1:0]     regs_q [NREGS];
  logic [W-1:0]     regs_d [NREGS];
  logic [NREGS-1:0] wr_hit;
  logic [NREGS-1:0] pending;

  always_comb begin : wr_decode
    logic [REG_MAX_WR-1:0] hit;
    hit = '0;
    for (int r = 0; r < NREGS; r++) begin
      hit = '0;
      for (int k = 0; k < NWR; k++) begin
        hit[k] = WRITE[k] && (INADDRESS[k*A +: A] == A'(r));
      end
      regs_d[r] = regs_q[r];
      wr_hit[r] = |hit;
      if (|hit) regs_d[r] = IN[wr_select(hit)*W +: W];
    end
    if (ZERO_REG != 0) begin
      regs_d[0] = '0;
      wr_hit[0] = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    for (int r = 0; r < NREGS; r++) begin
      if (RESET) regs_q[r] <= '0;
      else       regs_q[r] <= regs_d[r];
    end
  end

  reg_file_scoreboard #(
    .NREGS    (NREGS),
    .A        (A),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i      (CLK),
    .reset_i    (RESET),
    .clr_i      (wr_hit),
    .rsv_i      (RSV),
    .rsv_addr_i (RSVADDRESS),
    .pending_o  (pending)
  );

  always_comb begin : rd_mux
    logic [A-1:0] ra;
`ifdef REG_FILE_BYPASS_EN
    logic [REG_MAX_WR-1:0] fwd;
    fwd = '0;
`endif
    ra      = '0;
    OUT     = '0;
    OUTBUSY = '0;
    for (int j = 0; j < NRD; j++) begin
      ra             = OUTADDRESS[j*A +: A];
      OUT[j*W +: W]  = regs_q[ra];
      OUTBUSY[j]     = pending[ra];
`ifdef REG_FILE_BYPASS_EN
      // Forwarded reads show the post-edge view: new data, busy only if re-reserved.
      fwd = '0;
      for (int k = 0; k < NWR; k++) begin
        fwd[k] = WRITE[k] && (INADDRESS[k*A +: A] == ra);
      end
      if ((ZERO_REG != 0) && (ra == '0)) fwd = '0;
      if (|fwd) begin
        OUT[j*W +: W] = IN[wr_select(fwd)*W +: W];
        OUTBUSY[j]    = RSV && (RSVADDRESS == ra);
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed self-checking bench for reg_file_mp (plain and ZERO_REG=1 instances)
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  write;
  logic [5:0]  inaddr;
  logic [15:0] indata;
  logic [5:0]  outaddr;
  logic        rsv;
  logic [2:0]  rsvaddr;
  logic [15:0] out_a, out_z;
  logic [1:0]  busy_a, busy_z;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.ZERO_REG(0)) dut_a (
    .CLK(clk), .RESET(reset), .WRITE(write), .INADDRESS(inaddr), .IN(indata),
    .OUTADDRESS(outaddr), .OUT(out_a), .OUTBUSY(busy_a), .RSV(rsv), .RSVADDRESS(rsvaddr)
  );

  reg_file_mp #(.ZERO_REG(1)) dut_z (
    .CLK(clk), .RESET(reset), .WRITE(write), .INADDRESS(inaddr), .IN(indata),
    .OUTADDRESS(outaddr), .OUT(out_z), .OUTBUSY(busy_z), .RSV(rsv), .RSVADDRESS(rsvaddr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write = 2'b00;
    rsv   = 1'b0;
  endtask

  task automatic wr(input int port, input logic [2:0] addr, input logic [7:0] data);
    write[port]          = 1'b1;
    inaddr[port*3 +: 3]  = addr;
    indata[port*8 +: 8]  = data;
  endtask

  task automatic rd(input logic [2:0] a1, input logic [2:0] a0);
    outaddr = {a1, a0};
  endtask

  task automatic test_reset();
    reset = 1'b0;
    wr(0, 3'd3, 8'hAA);
    tick(); idle();
    rsv = 1'b1; rsvaddr = 3'd3;
    tick(); idle();
    rd(3'd3, 3'd3);
    #1;
    total++; if (out_a[7:0] !== 8'hAA) $display("FAIL pre_reset_r3 got %h exp %h", out_a[7:0], 8'hAA); else passed++;
    total++; if (busy_a !== 2'b11) $display("FAIL pre_reset_busy got %b exp %b", busy_a, 2'b11); else passed++;
    reset = 1'b1;
    wr(1, 3'd3, 8'hBB);
    rsv = 1'b1; rsvaddr = 3'd3;
    tick();
    reset = 1'b0; idle();
    #1;
    total++; if (out_a !== 16'h0000) $display("FAIL reset_out got %h exp %h", out_a, 16'h0000); else passed++;
    total++; if (busy_a !== 2'b00) $display("FAIL reset_busy got %b exp %b", busy_a, 2'b00); else passed++;
    total++; if (busy_z !== 2'b00) $display("FAIL reset_busy_z got %b exp %b", busy_z, 2'b00); else passed++;
  endtask

  task automatic test_dual_write();
    wr(0, 3'd2, 8'h11);
    wr(1, 3'd5, 8'h22);
    tick(); idle();
    rd(3'd5, 3'd2);
    #1;
    total++; if (out_a !== 16'h2211) $display("FAIL dual_write got %h exp %h", out_a, 16'h2211); else passed++;
  endtask

  task automatic test_collision();
    wr(0, 3'd4, 8'h33);
    wr(1, 3'd4, 8'h44);
    tick(); idle();
    rd(3'd4, 3'd4);
    #1;
    total++; if (out_a !== 16'h4444) $display("FAIL collision got %h exp %h", out_a, 16'h4444); else passed++;
  endtask

  task automatic test_scoreboard();
    rsv = 1'b1; rsvaddr = 3'd6;
    tick(); idle();
    rd(3'd2, 3'd6);
    #1;
    total++; if (busy_a !== 2'b01) $display("FAIL rsv_busy got %b exp %b", busy_a, 2'b01); else passed++;
    wr(0, 3'd6, 8'h55);
    tick(); idle();
    #1;
    total++; if (busy_a[0] !== 1'b0) $display("FAIL write_clears got %b exp %b", busy_a[0], 1'b0); else passed++;
    total++; if (out_a[7:0] !== 8'h55) $display("FAIL write_data r6 got %h exp %h", out_a[7:0], 8'h55); else passed++;
    rsv = 1'b1; rsvaddr = 3'd6;
    wr(1, 3'd6, 8'h66);
    tick(); idle();
    #1;
    total++; if (busy_a[0] !== 1'b1) $display("FAIL rsv_wins got %b exp %b", busy_a[0], 1'b1); else passed++;
    total++; if (out_a[7:0] !== 8'h66) $display("FAIL rsv_wins_data got %h exp %h", out_a[7:0], 8'h66); else passed++;
    rsv = 1'b1; rsvaddr = 3'd6;
    tick(); idle();
    #1;
    total++; if (busy_a[0] !== 1'b1) $display("FAIL rsv_again got %b exp %b", busy_a[0], 1'b1); else passed++;
    wr(0, 3'd2, 8'h12);
    tick(); idle();
    #1;
    total++; if (out_a[15:8] !== 8'h12) $display("FAIL nonpend_data got %h exp %h", out_a[15:8], 8'h12); else passed++;
    total++; if (busy_a[1] !== 1'b0) $display("FAIL nonpend_busy got %b exp %b", busy_a[1], 1'b0); else passed++;
    wr(1, 3'd6, 8'h67);
    tick(); idle();
    #1;
    total++; if (busy_a[0] !== 1'b0) $display("FAIL single_clear got %b exp %b", busy_a[0], 1'b0); else passed++;
  endtask

  task automatic test_zero_reg();
    wr(0, 3'd0, 8'hFF);
    rsv = 1'b1; rsvaddr = 3'd0;
    tick(); idle();
    rd(3'd0, 3'd0);
    #1;
    total++; if (out_z !== 16'h0000) $display("FAIL zero_out got %h exp %h", out_z, 16'h0000); else passed++;
    total++; if (busy_z !== 2'b00) $display("FAIL zero_busy got %b exp %b", busy_z, 2'b00); else passed++;
    total++; if (out_a[7:0] !== 8'hFF) $display("FAIL r0_plain got %h exp %h", out_a[7:0], 8'hFF); else passed++;
    total++; if (busy_a[0] !== 1'b1) $display("FAIL r0_plain_busy got %b exp %b", busy_a[0], 1'b1); else passed++;
  endtask

  task automatic test_read_during_write();
    wr(0, 3'd1, 8'h10);
    tick(); idle();
    rd(3'd0, 3'd1);
    wr(1, 3'd1, 8'h77);
    wr(0, 3'd0, 8'hEE);
    #1;
`ifdef REG_FILE_BYPASS_EN
    total++; if (out_a[7:0] !== 8'h77) $display("FAIL bypass_r1 got %h exp %h", out_a[7:0], 8'h77); else passed++;
    total++; if (out_a[15:8] !== 8'hEE) $display("FAIL bypass_r0 got %h exp %h", out_a[15:8], 8'hEE); else passed++;
`else
    total++; if (out_a[7:0] !== 8'h10) $display("FAIL nobypass_r1 got %h exp %h", out_a[7:0], 8'h10); else passed++;
    total++; if (out_a[15:8] !== 8'hFF) $display("FAIL nobypass_r0 got %h exp %h", out_a[15:8], 8'hFF); else passed++;
`endif
    total++; if (out_z[15:8] !== 8'h00) $display("FAIL zero_nofwd got %h exp %h", out_z[15:8], 8'h00); else passed++;
    tick(); idle();
    #1;
    total++; if (out_a[7:0] !== 8'h77) $display("FAIL after_write_r1 got %h exp %h", out_a[7:0], 8'h77); else passed++;
  endtask

  initial begin
    reset   = 1'b1;
    write   = 2'b00;
    inaddr  = '0;
    indata  = '0;
    outaddr = '0;
    rsv     = 1'b0;
    rsvaddr = '0;
    tick();
    tick();
    test_reset();
    test_dual_write();
    test_collision();
    test_scoreboard();
    test_zero_reg();
    test_read_during_write();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file for the next-generation core. It supports NRD combinational read ports and NWR synchronous write ports, and an optional hardwired zero register. A per-register pending-write scoreboard lets multi-cycle units reserve a destination and the decode stage detect hazards. Sits between decode (reads, reservations) and writeback (writes).

Parameters:
NREGS, 8, number of registers (power of 2, >=2)
W, 8, register width in bits
A, 3, address width; must equal $clog2(NREGS)
NRD, 2, number of read ports (>=1)
NWR, 2, number of write ports (>=1)
ZERO_REG, 0, 1 = register 0 reads 0 and ignores writes/reservations

Ports:
CLK  in  1  clock; all state updates on rising edge
RESET  in  1  synchronous, active-high reset
WRITE  in  NWR  per-port write enable
INADDRESS  in  NWR*A  write addresses, port k at [k*A +: A]
IN  in  NWR*W  write data, port k at [k*W +: W]
OUTADDRESS  in  NRD*A  read addresses, port j at [j*A +: A]
OUT  out  NRD*W  read data, port j at [j*W +: W]
OUTBUSY  out  NRD  1 = register addressed by read port j has a pending write
RSV  in  1  reserve request: mark RSVADDRESS pending
RSVADDRESS  in  A  register to reserve

Behaviour:
- Clock CLK only; reset is synchronous and active-high. RESET sampled high at a rising edge: all registers <= 0, all pending bits <= 0; WRITE and RSV in that cycle are ignored. From the following cycle OUT = 0 and OUTBUSY = 0 for every port.
- Reads: zero-cycle combinational. OUT[j] = reg[OUTADDRESS[j]]; OUTBUSY[j] = pending[OUTADDRESS[j]]. No delays in RTL.
- Writes: on the edge where WRITE[k]=1, reg[INADDRESS[k]] <= IN[k]. Data is visible on reads the following cycle.
- Write collision: when several enabled ports target the same address, the highest-index port wins. The others are dropped silently.
- Write clears pending: any enabled write to address a clears pending[a] on that edge.
- Reserve: RSV=1 sets pending[RSVADDRESS] on the edge.
- Reserve and write to the same address on the same edge: the reserve wins. Pending stays 1 and register data is updated.
- Reserve of an already pending register: pending stays 1. No counting; a single outstanding writer per register is assumed by issue logic.
- Write to a non-pending register: allowed; data is written and pending stays 0.
- ZERO_REG=1: reg[0] is constant 0, OUT reads 0, pending[0] is always 0, and writes and reserves to address 0 are ignored.
- Read and write to the same address in the same cycle (no bypass): OUT returns the old value.
- RESET asserted mid-operation, with reservations outstanding: everything clears and in-flight writebacks in the reset cycle are lost.

Optional Feature:
Macro REG_FILE_BYPASS_EN.
- Defined: write-to-read forwarding. If any WRITE[k]=1 and INADDRESS[k]==OUTADDRESS[j], OUT[j] = IN of the highest-index matching port. OUTBUSY[j] reflects the post-edge pending value: 0 unless RSV also targets that address.
- Undefined: reads return stored state only, as above.
- With ZERO_REG=1, forwarding never applies to address 0.

Decomposition:
- Package reg_file_pkg holds:
  - default constants REG_N=8, REG_W=8, REG_A=3;
  - typedef reg_addr_t (logic [REG_A-1:0]) and reg_data_t (logic [REG_W-1:0]);
  - function wr_select, which returns the winning port index for an address (shared by the write path and bypass).
- One sub-module, reg_file_scoreboard, holds the NREGS pending bits and the reserve/clear/reset priority logic. The data array and read muxes stay in the top module.

Test Plan:
- Reset: write 0xAA to r3, then RESET=1 for one edge -> OUT=0x00 and OUTBUSY=0 on all ports next cycle; a WRITE in the reset cycle is ignored.
- Dual write: port0 writes r2=0x11 and port1 writes r5=0x22 on one edge -> next cycle read r2=0x11, r5=0x22.
- Collision: port0 and port1 both write r4 (0x33, 0x44) -> r4=0x44.
- Scoreboard: RSV r6 -> OUTBUSY=1 for r6. Write r6=0x55 -> OUTBUSY=0, OUT=0x55. RSV r6 plus write r6=0x66 on the same edge -> OUTBUSY=1, OUT=0x66.
- ZERO_REG=1: write r0=0xFF and RSV r0 -> OUT=0x00, OUTBUSY=0.
- Bypass (REG_FILE_BYPASS_EN): read r1 while port1 writes r1=0x77 -> OUT=0x77 in the same cycle. Without the macro -> OUT shows the old value until the next cycle.
